// File: rtl/uart_pkg.sv
// Shared UART constants: parity_type encoding, RX FSM states, default bit period.
// Imported by the receiver and by the transmitter parity logic.
package uart_pkg;

   localparam logic [1:0] PAR_NONE      = 2'b00;
   localparam logic [1:0] PAR_EVEN      = 2'b01;
   localparam logic [1:0] PAR_ODD       = 2'b10;
   localparam logic [1:0] PAR_ODD_NOADD = 2'b11;

   localparam int CLKS_PER_BIT_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bundle: serial line + config in, byte + status out.
// slave = receiver side, master = the block feeding/consuming it.
interface uart_rx_if #(
   parameter int DATA_W = 8
);
   logic              rx;
   logic [1:0]        parity_type;
   logic              stop_bits;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              parity_error;
   logic              frame_error;
   logic              busy;

   modport slave (
      input  rx, parity_type, stop_bits,
      output rx_data, rx_valid, parity_error, frame_error, busy
   );

   modport master (
      output rx, parity_type, stop_bits,
      input  rx_data, rx_valid, parity_error, frame_error, busy
   );
endinterface

// File: rtl/uart_rx_parity_chk.sv
// Expected parity bit for a received byte under the given parity_type.
// Ports: data (received bits), parity_type, exp_bit (value the wire should carry).
module uart_rx_parity_chk
   import uart_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        parity_type,
   output logic              exp_bit
);

   always_comb begin
      exp_bit = 1'b0;
      unique case (parity_type)
         PAR_EVEN: exp_bit = ^data;
         PAR_ODD:  exp_bit = ~^data;
         default:  exp_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, start/data/parity/stop recovery, byte + status out.
// Ports: clk, rst (sync, active high), bus (uart_rx_if.slave). Macro RX_MAJORITY_VOTE_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_W       = 8
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_if.slave     bus
);

   localparam int CW = $clog2(CLKS_PER_BIT + 2);
   localparam int BW = $clog2(DATA_W + 1);

`ifdef RX_MAJORITY_VOTE_EN
   localparam int FIRST = CLKS_PER_BIT / 2 + 1;
`else
   localparam int FIRST = CLKS_PER_BIT / 2;
`endif

   localparam logic [CW-1:0] FIRST_C = CW'(FIRST);
   localparam logic [CW-1:0] BIT_C   = CW'(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST_C  = BW'(DATA_W - 1);

   rx_state_e         state_q, state_d;
   logic              sync1, rx_s, rx_d1;
   logic [1:0]        vld;
   logic              armed;
   logic              bit_val;
   logic              tick;
   logic              bit_last;
   logic              stop_last;
   logic [CW-1:0]     cnt_q;
   logic [BW-1:0]     bit_cnt_q;
   logic [DATA_W-1:0] shreg;
   logic [1:0]        ptype_q;
   logic              stop2_q;
   logic              perr_q, ferr_q;
   logic              exp_par;
   logic [DATA_W-1:0] data_o;
   logic              perr_o, ferr_o;

`ifdef RX_MAJORITY_VOTE_EN
   logic rx_d2;
   always_ff @(posedge clk) begin
      if (rst) rx_d2 <= 1'b1;
      else     rx_d2 <= rx_d1;
   end
   // Window is point-1..point+1, decided one cycle late.
   assign bit_val = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
   assign bit_val = rx_s;
`endif

   // vld tracks when rx_s reflects the real line instead of reset ones;
   // armed requires a genuine high before any falling edge counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d1 <= 1'b1;
         vld   <= 2'b00;
         armed <= 1'b0;
      end else begin
         sync1 <= bus.rx;
         rx_s  <= sync1;
         rx_d1 <= rx_s;
         vld   <= {vld[0], 1'b1};
         if (vld[1] && rx_s) armed <= 1'b1;
      end
   end

   assign tick      = (state_q == START) ? (cnt_q == FIRST_C)
                                         : (cnt_q == BIT_C);
   assign bit_last  = (bit_cnt_q == LAST_C);
   assign stop_last = !stop2_q || bit_cnt_q[0];

   uart_rx_parity_chk #(.DATA_W(DATA_W)) u_par (
      .data        (shreg),
      .parity_type (ptype_q),
      .exp_bit     (exp_par)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (armed && rx_d1 && !rx_s) state_d = START;
         START:
            if (tick) state_d = bit_val ? IDLE : DATA;
         DATA:
            if (tick && bit_last)
               state_d = (ptype_q == PAR_EVEN || ptype_q == PAR_ODD)
                         ? PARITY : STOP;
         PARITY:
            if (tick) state_d = STOP;
         STOP:
            if (tick && stop_last) state_d = DONE;
         DONE:
            state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shreg     <= '0;
         ptype_q   <= PAR_NONE;
         stop2_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         data_o    <= '0;
         perr_o    <= 1'b0;
         ferr_o    <= 1'b0;
      end else begin
         cnt_q <= (state_q == IDLE || tick) ? CW'(1) : cnt_q + 1'b1;
         if (state_q == IDLE) begin
            bit_cnt_q <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
         end
         if (state_q == START && tick) begin
            ptype_q <= bus.parity_type;
            stop2_q <= bus.stop_bits;
         end
         if (state_q == DATA && tick) begin
            shreg     <= {bit_val, shreg[DATA_W-1:1]};
            bit_cnt_q <= bit_last ? '0 : bit_cnt_q + 1'b1;
         end
         if (state_q == PARITY && tick && (bit_val != exp_par))
            perr_q <= 1'b1;
         if (state_q == STOP && tick) begin
            if (!bit_val) ferr_q <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end
         // The final stop sample is folded in directly.
         if (state_q == STOP && state_d == DONE) begin
            data_o <= shreg;
            perr_o <= perr_q;
            ferr_o <= ferr_q | ~bit_val;
         end
      end
   end

   assign bus.rx_data      = data_o;
   assign bus.parity_error = perr_o;
   assign bus.frame_error  = ferr_o;
   assign bus.rx_valid     = (state_q == DONE);
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_W=8).
// Frames are driven bit by bit; a monitor records each rx_valid pulse.
module tb_uart_rx;

   localparam int CPB = 16;

`ifdef RX_MAJORITY_VOTE_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   // Drive-to-observe latency of rx_valid for 8N1: 2 sync + T+153.
   localparam int L8N1 = 155 + EXTRA;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   ncmp = 0;
   int   nfail = 0;
   int   nvalid = 0;
   int   v_cyc = 0;
   int   t0 = 0;
   int   prev = 0;
   logic [7:0] vdat [0:63];
   logic       vperr [0:63];
   logic       vferr [0:63];

   uart_rx_if #(.DATA_W(8)) bus ();

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         if (nvalid < 64) begin
            vdat[nvalid]  = bus.rx_data;
            vperr[nvalid] = bus.parity_error;
            vferr[nvalid] = bus.frame_error;
         end
         v_cyc  = cyc;
         nvalid = nvalid + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold();
      repeat (CPB) @(negedge clk);
   endtask

   // Called at a negedge; leaves the line high at a negedge.
   task automatic send(input logic [7:0] d, input bit par_en,
                       input bit pbit, input bit s1, input bit two,
                       input bit s2, input int idle);
      bus.rx = 1'b1;
      repeat (idle) @(negedge clk);
      bus.rx = 1'b0;
      t0 = cyc;
      hold();
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         hold();
      end
      if (par_en) begin
         bus.rx = pbit;
         hold();
      end
      bus.rx = s1;
      hold();
      if (two) begin
         bus.rx = s2;
         hold();
      end
      bus.rx = 1'b1;
   endtask

   task automatic frame_chk(input string tag, input logic [7:0] d,
                            input bit pe, input bit fe, input int lat);
      repeat (20) @(negedge clk);
      chk({tag, "_cnt"}, nvalid, prev + 1);
      chk({tag, "_lat"}, v_cyc - t0, lat);
      chk({tag, "_data"}, vdat[prev], d);
      chk({tag, "_perr"}, vperr[prev], pe);
      chk({tag, "_ferr"}, vferr[prev], fe);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      prev = nvalid;
   endtask

   initial begin
      bus.rx = 1'b1;
      bus.parity_type = 2'b00;
      bus.stop_bits = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_valid", bus.rx_valid, 1'b0);
      chk("rst_data", bus.rx_data, 8'h00);
      chk("rst_perr", bus.parity_error, 1'b0);
      chk("rst_ferr", bus.frame_error, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // 8N1 0xA5
      send(8'hA5, 0, 0, 1, 0, 1, 0);
      frame_chk("8n1_a5", 8'hA5, 0, 0, L8N1);

      // Even parity: ^0x03 = 0
      bus.parity_type = 2'b01;
      send(8'h03, 1, 0, 1, 0, 1, 0);
      frame_chk("even_ok", 8'h03, 0, 0, L8N1 + 16);
      send(8'h03, 1, 1, 1, 0, 1, 0);
      frame_chk("even_bad", 8'h03, 1, 0, L8N1 + 16);

      // Odd parity: ~^0x07 = 0
      bus.parity_type = 2'b10;
      send(8'h07, 1, 0, 1, 0, 1, 0);
      frame_chk("odd_ok", 8'h07, 0, 0, L8N1 + 16);

      // Odd-not-on-wire: no parity bit, 8N1 timing
      bus.parity_type = 2'b11;
      send(8'h07, 0, 0, 1, 0, 1, 0);
      frame_chk("odd_noadd", 8'h07, 0, 0, L8N1);

      // Two stop bits, second low -> framing error
      bus.parity_type = 2'b00;
      bus.stop_bits = 1'b1;
      send(8'h3C, 0, 0, 1, 1, 0, 0);
      frame_chk("stop2_bad", 8'h3C, 0, 1, L8N1 + 16);
      send(8'h5A, 0, 0, 1, 1, 1, 8);
      frame_chk("stop2_ok", 8'h5A, 0, 0, L8N1 + 16);

      // 4-cycle glitch -> false start
      bus.stop_bits = 1'b0;
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx = 1'b1;
      chk("glitch_busy_hi", bus.busy, 1'b1);
      repeat (30) @(negedge clk);
      chk("glitch_busy_lo", bus.busy, 1'b0);
      chk("glitch_novalid", nvalid, prev);

      // Back-to-back 0x00 then 0xFF
      send(8'h00, 0, 0, 1, 0, 1, 0);
      send(8'hFF, 0, 0, 1, 0, 1, 0);
      repeat (20) @(negedge clk);
      chk("b2b_cnt", nvalid, prev + 2);
      chk("b2b_d0", vdat[prev], 8'h00);
      chk("b2b_d1", vdat[prev + 1], 8'hFF);
      chk("b2b_lat", v_cyc - t0, L8N1);
      prev = nvalid;

      // Reset during DATA, line held low across release
      bus.rx = 1'b0;
      hold();
      bus.rx = 1'b1;
      hold();
      hold();
      chk("mid_busy", bus.busy, 1'b1);
      rst = 1'b1;
      bus.rx = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_valid", bus.rx_valid, 1'b0);
      chk("mid_rst_data", bus.rx_data, 8'h00);
      chk("mid_rst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("low_rel_busy", bus.busy, 1'b0);
      chk("low_rel_novalid", nvalid, prev);
      send(8'h81, 0, 0, 1, 0, 1, 4);
      frame_chk("after_rst", 8'h81, 0, 0, L8N1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
